alu_mc: RTL

//  Parametrised multi-cycle ALU for the MIPS datapath; successor to the combinational ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 70 +++++++
 rtl/alu_mc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU (alu_mc).
// Operation codes, FSM state encoding and the default select width live here.
package alu_pkg;

    localparam int SEL_W = 4;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_EQU  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_NOR  = 4'b1100,
        OP_MUL  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier used by alu_mc when ALU_MUL_EN is defined.
// One partial product per cycle for WIDTH cycles; done_o is raised during the
// last iteration and product_o then carries the finished low WIDTH bits.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             run_q,    run_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;

    // Next-state: load operands on start, otherwise one shift-add step per cycle.
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = CW'(WIDTH);
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end else if (run_q) begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    // State registers; reset aborts any multiply in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // The final partial product is forwarded so the caller can latch it on the
    // same edge that completes the last iteration.
    assign done_o    = run_q & (cnt_q == CW'(1));
    assign product_o = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result and valid/ready handshakes.
// Optional feature macro: ALU_MUL_EN enables the iterative MUL (code 1111);
// without it 1111 is treated as an unknown op (result 0, flag_z 0, 1 cycle).
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = alu_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_v_q, flag_v_d;

    logic [WIDTH-1:0] res_c;
    logic             known_c;
    logic             v_c;
    logic             z_c;
    logic             is_mul_c;
    logic [WIDTH-1:0] sum_add;
    logic [WIDTH-1:0] b_neg;
    logic [WIDTH-1:0] sum_sub;
    logic [SH_W-1:0]  sh;
    logic             accept;

    // Single-cycle operation decode, result and flag computation.
    always_comb begin
        sum_add  = operand1 + operand2;
        b_neg    = ~operand2 + WIDTH'(1);
        sum_sub  = operand1 + b_neg;
        sh       = operand2[SH_W-1:0];
        res_c    = '0;
        known_c  = 1'b1;
        v_c      = 1'b0;
        is_mul_c = 1'b0;
        case (alu_sel)
            OP_AND:  res_c = operand1 & operand2;
            OP_OR:   res_c = operand1 | operand2;
            OP_ADD: begin
                res_c = sum_add;
                v_c   = (operand1[MSB] == operand2[MSB]) && (sum_add[MSB] != operand1[MSB]);
            end
            OP_XOR:  res_c = operand1 ^ operand2;
            OP_SLL:  res_c = operand1 << sh;
            OP_EQU:  res_c = WIDTH'(operand1 == operand2);
            OP_SUB: begin
                res_c = sum_sub;
                v_c   = (operand1[MSB] == b_neg[MSB]) && (sum_sub[MSB] != operand1[MSB]);
            end
            OP_SLT:  res_c = WIDTH'($signed(operand1) < $signed(operand2));
            OP_SLTU: res_c = WIDTH'(operand1 < operand2);
            OP_SRL:  res_c = operand1 >> sh;
            OP_SRA:  res_c = WIDTH'($signed(operand1) >>> sh);
            OP_NOR:  res_c = ~(operand1 | operand2);
`ifdef ALU_MUL_EN
            OP_MUL:  is_mul_c = 1'b1;
`endif
            default: known_c = 1'b0;
        endcase
        z_c = known_c && (res_c == '0);
    end

    // Accept whenever no multiply is running and any held result is leaving.
    assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept    = in_valid & in_ready;

`ifdef ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign mul_start = accept & is_mul_c;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (operand1),
        .b_i       (operand2),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`endif

    // FSM next state and output register load.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_v_d = flag_v_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_mul_c) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = res_c;
                        flag_z_d = z_c;
                        flag_v_d = v_c;
                    end
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_prod;
                    flag_z_d = (mul_prod == '0);
                    flag_v_d = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;

endmodule
